// File: rtl/pwm_mem_write_if.sv
// Ws AXI-Stream channel carrying packed coefficient pairs back to the PS.
interface pwm_mem_write_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/pwm_mem_write.sv
// Streams NUM_COEF coefficients out of the dual-port BRAM as 64-bit Ws beats,
// one even/odd pair per beat, through a 2-entry credit-protected FIFO.
module pwm_mem_write #(
  parameter int unsigned COEF_W   = 23,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned NUM_COEF = 256
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              module_start,
  output logic              busy,
  output logic              module_done,
  output logic              coef_ena,
  output logic              coef_wea,
  output logic [ADDR_W-1:0] coef_addra,
  input  logic [COEF_W-1:0] coef_douta,
  output logic              coef_enb,
  output logic              coef_web,
  output logic [ADDR_W-1:0] coef_addrb,
  input  logic [COEF_W-1:0] coef_doutb,
  pwm_mem_write_if.master   ws
);

  localparam int unsigned BEATS = NUM_COEF / 2;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   wr_cnt;
  logic [ADDR_W-1:0]  addr_a;
  logic [ADDR_W-1:0]  addr_b;
  logic               rd_vld;
  logic               rd_last;
  logic               head_v;
  logic               head_last;
  logic [63:0]        head_data;
  logic               tail_v;
  logic               tail_last;
  logic [63:0]        tail_data;
  logic [63:0]        push_data_c;
  logic [2:0]         occ_c;
  logic               pop_c;
  logic               issue_c;

  // Occupancy counts FIFO entries plus the read whose data lands at the next edge;
  // a pop in the same cycle frees a slot, which is what sustains one beat per cycle.
  always_comb begin
    push_data_c = {32'(coef_doutb), 32'(coef_douta)};
    pop_c       = head_v & ws.tready;
    occ_c       = 3'(head_v) + 3'(tail_v) + 3'(rd_vld);
    issue_c     = (state == S_SEND) && (rd_cnt < CNT_W'(BEATS)) &&
                  (occ_c < (3'd2 + 3'(pop_c)));
  end

  assign coef_ena   = issue_c;
  assign coef_enb   = issue_c;
  assign coef_wea   = 1'b0;
  assign coef_web   = 1'b0;
  assign coef_addra = addr_a;
  assign coef_addrb = addr_b;

  assign ws.tvalid = head_v;
  assign ws.tdata  = head_data;
  assign ws.tlast  = head_last;
  assign ws.tkeep  = 8'hFF;

  // Control FSM with frame counters and read address generation.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      module_done <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      addr_a      <= '0;
      addr_b      <= '0;
    end else begin
      module_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (module_start) begin
            state  <= S_SEND;
            busy   <= 1'b1;
            rd_cnt <= '0;
            wr_cnt <= '0;
            addr_a <= '0;
            addr_b <= ADDR_W'(1);
          end
        end
        S_SEND: begin
          if (issue_c) begin
            rd_cnt <= rd_cnt + CNT_W'(1);
            if (rd_cnt != CNT_W'(BEATS - 1)) begin
              addr_a <= addr_a + ADDR_W'(2);
              addr_b <= addr_b + ADDR_W'(2);
            end
          end
          if (pop_c) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == CNT_W'(BEATS - 1)) begin
              state       <= S_DONE;
              module_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-return pipeline and 2-entry FIFO; the head entry is the Ws output register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_vld    <= 1'b0;
      rd_last   <= 1'b0;
      head_v    <= 1'b0;
      head_last <= 1'b0;
      head_data <= '0;
      tail_v    <= 1'b0;
      tail_last <= 1'b0;
      tail_data <= '0;
    end else begin
      rd_vld  <= issue_c;
      rd_last <= issue_c && (rd_cnt == CNT_W'(BEATS - 1));
      case ({rd_vld, pop_c})
        2'b10: begin
          if (!head_v) begin
            head_v    <= 1'b1;
            head_data <= push_data_c;
            head_last <= rd_last;
          end else begin
            tail_v    <= 1'b1;
            tail_data <= push_data_c;
            tail_last <= rd_last;
          end
        end
        2'b01: begin
          if (tail_v) begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_v    <= 1'b0;
          end else begin
            head_v    <= 1'b0;
            head_data <= '0;
            head_last <= 1'b0;
          end
        end
        2'b11: begin
          if (tail_v) begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data_c;
            tail_last <= rd_last;
          end else begin
            head_data <= push_data_c;
            head_last <= rd_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
